// File: rtl/switch_2x2_sched_if.sv
// rtl/switch_2x2_sched_if.sv - handshake bundle for the 2x2 switch scheduler ports
interface switch_2x2_sched_if #(
   parameter int DW = 32
);
   logic          inA_valid;
   logic [DW-1:0] inA_data;
   logic [3:0]    inA_da;
   logic          inA_ready;

   logic          inB_valid;
   logic [DW-1:0] inB_data;
   logic [3:0]    inB_da;
   logic          inB_ready;

   logic          outA_valid;
   logic [DW-1:0] outA_data;
   logic          outA_ready;

   logic          outB_valid;
   logic [DW-1:0] outB_data;
   logic          outB_ready;

   modport master (
      output inA_valid, inA_data, inA_da,
      input  inA_ready,
      output inB_valid, inB_data, inB_da,
      input  inB_ready,
      input  outA_valid, outA_data,
      output outA_ready,
      input  outB_valid, outB_data,
      output outB_ready
   );

   modport slave (
      input  inA_valid, inA_data, inA_da,
      output inA_ready,
      input  inB_valid, inB_data, inB_da,
      output inB_ready,
      output outA_valid, outA_data,
      input  outA_ready,
      output outB_valid, outB_data,
      input  outB_ready
   );
endinterface

// File: rtl/switch_2x2_sched.sv
// rtl/switch_2x2_sched.sv - round-robin 2x2 scheduler with registered valid/ready outputs
// Illegal destinations are accepted and discarded; a saturating counter records them.
module switch_2x2_sched #(
   parameter int DW      = 32,
   parameter int DROP_CW = 8
) (
   input  logic               clk,
   input  logic               resetN,
   switch_2x2_sched_if.slave  sw,
   output logic [DROP_CW-1:0] drop_cnt
);

   logic          reqA_oA, reqA_oB, reqB_oA, reqB_oB;
   logic          illA, illB;
   logic          load_okA, load_okB;
   logic          selA_b, selA_a, selB_b, selB_a;
   logic          accA, accB;

   logic          outA_valid_q, outA_valid_d;
   logic          outB_valid_q, outB_valid_d;
   logic [DW-1:0] outA_data_q, outA_data_d;
   logic [DW-1:0] outB_data_q, outB_data_d;
   logic          rrA_q, rrA_d;
   logic          rrB_q, rrB_d;
   logic [DROP_CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [1:0]         drop_inc;
   logic [DROP_CW:0]   drop_sum;

   always_comb begin
      reqA_oA = sw.inA_valid && (sw.inA_da == 4'b0001);
      reqA_oB = sw.inA_valid && (sw.inA_da == 4'b0010);
      reqB_oA = sw.inB_valid && (sw.inB_da == 4'b0001);
      reqB_oB = sw.inB_valid && (sw.inB_da == 4'b0010);
      illA    = sw.inA_valid && !reqA_oA && !reqA_oB;
      illB    = sw.inB_valid && !reqB_oA && !reqB_oB;
   end

   assign load_okA = !outA_valid_q || sw.outA_ready;
   assign load_okB = !outB_valid_q || sw.outB_ready;

   // Input B wins an output when alone, or when contending with the pointer set to B.
   always_comb begin
      selA_b = reqB_oA && (!reqA_oA || rrA_q);
      selA_a = reqA_oA && !selA_b;
      selB_b = reqB_oB && (!reqA_oB || rrB_q);
      selB_a = reqA_oB && !selB_b;
      accA   = load_okA && (selA_a || selA_b);
      accB   = load_okB && (selB_a || selB_b);
   end

   assign sw.inA_ready = illA || (selA_a && load_okA) || (selB_a && load_okB);
   assign sw.inB_ready = illB || (selA_b && load_okA) || (selB_b && load_okB);

   always_comb begin
      outA_valid_d = outA_valid_q;
      outA_data_d  = outA_data_q;
      rrA_d        = rrA_q;
      if (accA) begin
         outA_valid_d = 1'b1;
         outA_data_d  = selA_b ? sw.inB_data : sw.inA_data;
         rrA_d        = !selA_b;
      end else if (sw.outA_ready) begin
         outA_valid_d = 1'b0;
      end
   end

   always_comb begin
      outB_valid_d = outB_valid_q;
      outB_data_d  = outB_data_q;
      rrB_d        = rrB_q;
      if (accB) begin
         outB_valid_d = 1'b1;
         outB_data_d  = selB_b ? sw.inB_data : sw.inA_data;
         rrB_d        = !selB_b;
      end else if (sw.outB_ready) begin
         outB_valid_d = 1'b0;
      end
   end

   // One extra sum bit catches the carry so the counter clamps instead of wrapping.
   always_comb begin
      drop_inc   = {1'b0, illA} + {1'b0, illB};
      drop_sum   = {1'b0, drop_cnt_q} + {{(DROP_CW-1){1'b0}}, drop_inc};
      drop_cnt_d = drop_sum[DROP_CW] ? {DROP_CW{1'b1}} : drop_sum[DROP_CW-1:0];
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         outA_valid_q <= 1'b0;
         outB_valid_q <= 1'b0;
         outA_data_q  <= '0;
         outB_data_q  <= '0;
         rrA_q        <= 1'b0;
         rrB_q        <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         outA_valid_q <= outA_valid_d;
         outB_valid_q <= outB_valid_d;
         outA_data_q  <= outA_data_d;
         outB_data_q  <= outB_data_d;
         rrA_q        <= rrA_d;
         rrB_q        <= rrB_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign sw.outA_valid = outA_valid_q;
   assign sw.outA_data  = outA_data_q;
   assign sw.outB_valid = outB_valid_q;
   assign sw.outB_data  = outB_data_q;
   assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_switch_2x2_sched.sv
// tb/tb_switch_2x2_sched.sv - directed and randomized bench against a behavioural switch model
module tb_switch_2x2_sched;
   localparam int DW      = 32;
   localparam int DROP_CW = 8;
   localparam int DROP_MAX = (1 << DROP_CW) - 1;

   logic               clk = 1'b0;
   logic               resetN;
   logic [DROP_CW-1:0] drop_cnt;

   switch_2x2_sched_if #(.DW(DW)) sif ();

   switch_2x2_sched #(.DW(DW), .DROP_CW(DROP_CW)) dut (
      .clk      (clk),
      .resetN   (resetN),
      .sw       (sif),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   // stimulus: index 0 = input/output A, 1 = input/output B
   bit          in_v[2];
   logic [31:0] in_d[2];
   logic [3:0]  in_da[2];
   bit          out_rdy[2];

   always_comb begin
      sif.inA_valid  = in_v[0];
      sif.inA_data   = in_d[0];
      sif.inA_da     = in_da[0];
      sif.inB_valid  = in_v[1];
      sif.inB_data   = in_d[1];
      sif.inB_da     = in_da[1];
      sif.outA_ready = out_rdy[0];
      sif.outB_ready = out_rdy[1];
   end

   // reference model: held word per output, priority side per output, drop total
   bit          m_v[2];
   logic [31:0] m_d[2];
   int          m_prio[2];
   int          m_drops;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      for (int o = 0; o < 2; o++) begin
         m_v[o]    = 1'b0;
         m_d[o]    = '0;
         m_prio[o] = 0;
      end
      m_drops = 0;
   endfunction

   // Checks DUT state and readies against the model, then advances both by one clock.
   task automatic cycle(output bit [1:0] acc);
      int dest[2];
      int nill;
      int w;
      bit can;
      logic [31:0] got_d[2];
      #1;
      got_d[0] = sif.outA_data;
      got_d[1] = sif.outB_data;
      check("outA_valid", sif.outA_valid, m_v[0]);
      check("outB_valid", sif.outB_valid, m_v[1]);
      if (m_v[0]) check("outA_data", got_d[0], m_d[0]);
      if (m_v[1]) check("outB_data", got_d[1], m_d[1]);
      check("drop_cnt", drop_cnt, m_drops);
      nill = 0;
      acc  = 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (!in_v[i])                dest[i] = -2;
         else if (in_da[i] == 4'd1)   dest[i] = 0;
         else if (in_da[i] == 4'd2)   dest[i] = 1;
         else begin dest[i] = -1; nill++; acc[i] = 1'b1; end
      end
      for (int o = 0; o < 2; o++) begin
         can = !m_v[o] || out_rdy[o];
         w = -1;
         if (dest[0] == o && dest[1] == o) w = m_prio[o];
         else if (dest[0] == o)            w = 0;
         else if (dest[1] == o)            w = 1;
         if (can && w >= 0) begin
            acc[w]    = 1'b1;
            m_v[o]    = 1'b1;
            m_d[o]    = in_d[w];
            m_prio[o] = 1 - w;
         end else if (out_rdy[o]) begin
            m_v[o] = 1'b0;
         end
      end
      check("inA_ready", sif.inA_ready, acc[0]);
      check("inB_ready", sif.inB_ready, acc[1]);
      m_drops = (m_drops + nill > DROP_MAX) ? DROP_MAX : m_drops + nill;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      for (int i = 0; i < 2; i++) begin
         in_v[i] = 1'b0; in_d[i] = '0; in_da[i] = '0; out_rdy[i] = 1'b1;
      end
      resetN = 1'b0;
      #1;
      check("rst_outA_valid", sif.outA_valid, 0);
      check("rst_outB_valid", sif.outB_valid, 0);
      check("rst_outA_data", sif.outA_data, 0);
      check("rst_outB_data", sif.outB_data, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      check("rst_inA_ready", sif.inA_ready, 0);
      model_clear();
      @(negedge clk);
      resetN = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic void set_in(int i, bit v, logic [3:0] da, logic [31:0] d);
      in_v[i] = v; in_da[i] = da; in_d[i] = d;
   endfunction

   bit [1:0]    acc;
   int          ka, kb;
   logic [31:0] seq_exp;
   logic [3:0]  rda;
   int          r;

   initial begin
      resetN = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_v[i] = 1'b0; in_d[i] = '0; in_da[i] = '0; out_rdy[i] = 1'b1;
      end
      #2;
      do_reset();

      // parallel paths
      set_in(0, 1, 4'b0001, 32'hAAAA0001);
      set_in(1, 1, 4'b0010, 32'hBBBB0002);
      cycle(acc);
      check("par_acc", acc, 2'b11);
      set_in(0, 0, 4'b0000, '0);
      set_in(1, 0, 4'b0000, '0);
      check("par_outA_data", sif.outA_data, 32'hAAAA0001);
      check("par_outB_data", sif.outB_data, 32'hBBBB0002);
      check("par_valids", {sif.outA_valid, sif.outB_valid}, 2'b11);
      cycle(acc);

      // contention on output B: strict alternation starting with A after reset
      do_reset();
      ka = 0; kb = 0;
      for (int c = 0; c < 6; c++) begin
         set_in(0, 1, 4'b0010, 32'hA0000000 + ka);
         set_in(1, 1, 4'b0010, 32'hB0000000 + kb);
         cycle(acc);
         seq_exp = (c % 2 == 0) ? 32'hA0000000 + c / 2 : 32'hB0000000 + c / 2;
         check("cont_seq", sif.outB_data, seq_exp);
         if (acc[0]) ka++;
         if (acc[1]) kb++;
      end
      check("cont_counts", {ka[7:0], kb[7:0]}, {8'd3, 8'd3});
      set_in(0, 0, 4'b0000, '0);
      set_in(1, 0, 4'b0000, '0);
      cycle(acc);

      // backpressure on output A
      do_reset();
      set_in(0, 1, 4'b0001, 32'h11110001);
      cycle(acc);
      out_rdy[0] = 1'b0;
      set_in(0, 1, 4'b0001, 32'h11110002);
      for (int c = 0; c < 3; c++) begin
         cycle(acc);
         check("bp_inA_ready", acc[0], 0);
         check("bp_outA_hold", sif.outA_data, 32'h11110001);
      end
      out_rdy[0] = 1'b1;
      cycle(acc);
      check("bp_release_acc", acc[0], 1);
      set_in(0, 0, 4'b0000, '0);
      check("bp_outA_new", sif.outA_data, 32'h11110002);
      cycle(acc);

      // illegal destinations in the same cycle
      do_reset();
      set_in(0, 1, 4'b0100, 32'hDEAD0001);
      set_in(1, 1, 4'b0000, 32'hDEAD0002);
      cycle(acc);
      check("ill_acc", acc, 2'b11);
      check("ill_drop", drop_cnt, 2);
      check("ill_no_valid", {sif.outA_valid, sif.outB_valid}, 2'b00);

      // saturation
      set_in(1, 0, 4'b0000, '0);
      for (int c = 0; c < 300; c++) begin
         set_in(0, 1, 4'b0011 + c[3:0] % 4'd13, 32'hC0000000 + c);
         if (in_da[0] == 4'b0001 || in_da[0] == 4'b0010) in_da[0] = 4'b1111;
         cycle(acc);
      end
      check("sat_drop", drop_cnt, DROP_MAX);
      set_in(0, 0, 4'b0000, '0);
      cycle(acc);

      // randomized traffic against the model
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!in_v[i] || acc[i]) begin
               r = $urandom_range(0, 9);
               if (r < 4)      rda = 4'b0001;
               else if (r < 8) rda = 4'b0010;
               else begin
                  r = $urandom_range(3, 16);
                  rda = (r == 16) ? 4'b0000 : r[3:0];
               end
               set_in(i, $urandom_range(0, 3) != 0, rda, $urandom);
            end
            out_rdy[i] = $urandom_range(0, 9) < 7;
         end
         cycle(acc);
      end

      // asynchronous reset mid-traffic, then A wins first contention
      set_in(0, 1, 4'b0001, 32'h55550001);
      set_in(1, 1, 4'b0001, 32'h66660001);
      out_rdy[0] = 1'b0;
      #3;
      do_reset();
      set_in(0, 1, 4'b0001, 32'h55550001);
      set_in(1, 1, 4'b0001, 32'h66660001);
      cycle(acc);
      check("post_rst_acc", acc, 2'b01);
      check("post_rst_outA", sif.outA_data, 32'h55550001);
      cycle(acc);
      check("post_rst_outA2", sif.outA_data, 32'h66660001);
      set_in(0, 0, 4'b0000, '0);
      set_in(1, 0, 4'b0000, '0);
      cycle(acc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/switch_2x2_sched.md
# switch_2x2_sched

Round-robin scheduler and output stage for the 2x2 32-bit switch. It accepts words on two input ports, each tagged with a 4-bit one-hot destination address, and resolves contention when both inputs target the same output. It registers each output with a valid/ready handshake. Illegal destinations are dropped and counted. The block sits between the ingress MACs and the egress ports and replaces fixed-priority overwrite with fair, lossless arbitration.

## Interface
- DW, 32, data word width
- DROP_CW, 8, width of the drop counter
- clk  in  1  clock; all logic on rising edge
- resetN  in  1  reset, asynchronous, active-low
- inA_valid  in  1  input port A word valid
- inA_data  in  DW  input port A word
- inA_da  in  4  input A destination: 4'b0001 = out A, 4'b0010 = out B
- inA_ready  out  1  input A word accepted this cycle
- inB_valid / inB_data / inB_da / inB_ready  same as port A, for input B
- outA_valid  out  1  output A holds a word
- outA_data  out  DW  output A word
- outA_ready  in  1  output A downstream accepts
- outB_valid / outB_data / outB_ready  same as output A, for output B
- drop_cnt  out  DROP_CW  saturating count of dropped words

## Operation
- Decode per input, qualified by valid:
  - da==0001 requests output A.
  - da==0010 requests output B.
  - Any other value (0000, 0011, 0100..1111) is illegal.
- Illegal words:
  - ready=1 in the same cycle; word discarded.
  - drop_cnt += 1, or += 2 if both inputs are illegal in the same cycle.
  - drop_cnt saturates at all-ones; it never wraps.
- Output register load condition, per output: load_ok = !out_valid || out_ready.
- Arbitration, per output, with one round-robin pointer per output (rrA, rrB; 0 = input A has priority, 1 = input B):
  - One requester: it wins.
  - Two requesters: the pointer side wins.
  - After any grant on that output, the pointer moves to the non-granted input.
  - The pointer is unchanged when there is no grant.
- inX_ready = illegal_X || (granted_X && load_ok of its target output). This is combinational from valid/da/out_ready.
- Inputs targeting different outputs are both accepted in the same cycle.
- Inputs targeting the same output: exactly one is accepted. The loser sees ready=0 and must hold valid/data/da stable until accepted.
- A sender must not withdraw valid or change data/da while valid=1 and ready=0.
- Output update:
  - On accept, out_data <= winning data and out_valid <= 1.
  - If out_ready=1 and nothing is loaded, out_valid <= 0; out_data holds its last value.
- No word is duplicated, reordered within an input, or lost except for illegal drops.

## Timing
- Reset (async assert, sync-safe release) values:
  - outA_valid = outB_valid = 0
  - outA_data = outB_data = 0
  - drop_cnt = 0
  - rrA = rrB = 0
  - inX_ready follows the decode combinationally (0 while valid=0).
- Latency: a word accepted at edge t appears with out_valid=1 after edge t, i.e. one cycle.
- Throughput: one word per cycle per output with out_ready held at 1.
- Under continuous contention with out_ready=1, each input is served every other cycle on the shared output.
- Backpressure: with out_ready=0 and out_valid=1, no requester for that output gets ready; the word and out_data are held.
- Reset mid-operation: registered words are lost, pointers return to 0, and drop_cnt is cleared.

## Test plan
- Reset: assert resetN=0 mid-traffic -> all outputs valid=0, data=0, drop_cnt=0 immediately. After release, A and B both to output A -> A wins first.
- Parallel paths:
  - inA (da=0001, data=AAAA0001) and inB (da=0010, data=BBBB0002) in the same cycle.
  - Both ready=1.
  - Next cycle: outA_data=AAAA0001 and outB_data=BBBB0002, both valid.
- Contention fairness: both inputs continuously target output B, with outB_ready=1, for 6 cycles -> outB sequence alternates A,B,A,B,A,B; no word lost.
- Backpressure:
  - outA_ready=0 for 3 cycles with inA pending (da=0001) -> inA_ready=0 and outA word held.
  - Release outA_ready -> pending word appears the next cycle.
- Illegal destinations: inA da=0100 and inB da=0000 in the same cycle -> both ready=1, drop_cnt +2, no output valid change.
- Saturation: 300 illegal words with DROP_CW=8 -> drop_cnt stops at 255.
